// File: rtl/ipv4_rx_parser.sv
// IPv4 receive parser: validates a 20-byte IPv4 header, presents its fields, forwards the payload.
// Optional header checksum verification when IPV4_CSUM_CHECK_EN is defined.
module ipv4_rx_parser #(
  parameter int unsigned IP_FILTER = 0,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0164
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        header_valid,
  output logic        header_rd,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        ip_hdr_valid,
  input  logic        ip_hdr_ready,
  output logic [47:0] ip_src_mac,
  output logic [31:0] ip_src_addr,
  output logic [31:0] ip_dst_addr,
  output logic [7:0]  ip_protocol,
  output logic [15:0] ip_payload_len,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic [15:0] drop_count
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HOLD, S_PAYLOAD, S_DROP} state_t;

  state_t      state, state_nx;
  logic [4:0]  byte_cnt;
  logic [7:0]  vihl;
  logic [15:0] tot_len;
  logic [15:0] remaining;
  logic        drop_inc;
  logic        s_hs;
  logic [31:0] dst_full;
  logic        hdr_bad;
  logic        csum_bad;
  logic        unused_dest_mac;

  assign unused_dest_mac = ^dest_mac;
  assign s_hs            = s_axis_tvalid && s_axis_tready;
  // Byte 19 is still on the bus when the header is judged
  assign dst_full        = {ip_dst_addr[23:0], s_axis_tdata};
  assign ip_hdr_valid    = (state == S_HOLD);

`ifdef IPV4_CSUM_CHECK_EN
  logic [15:0] csum;
  logic [7:0]  csum_hi;
  logic [16:0] csum_sum;
  logic [15:0] csum_next;

  assign csum_sum  = {1'b0, csum} + {1'b0, csum_hi, s_axis_tdata};
  assign csum_next = csum_sum[15:0] + {15'd0, csum_sum[16]};
  assign csum_bad  = (csum_next != 16'hFFFF);
`else
  assign csum_bad  = 1'b0;
`endif

  assign hdr_bad = (vihl != 8'h45) || (tot_len < 16'd20) ||
                   ((IP_FILTER == 1) && (dst_full != LOCAL_IP)) || csum_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    s_axis_tready = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    drop_inc      = 1'b0;
    case (state)
      S_IDLE: begin
        if (header_valid) begin
          if (ethertype == 16'h0800) begin
            state_nx = S_HDR;
          end else begin
            state_nx = S_DROP;
            drop_inc = 1'b1;
          end
        end
      end
      S_HDR: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tlast) begin
            state_nx = S_IDLE;
            drop_inc = 1'b1;
          end else if (byte_cnt == 5'd19) begin
            state_nx = hdr_bad ? S_DROP : S_HOLD;
            drop_inc = hdr_bad;
          end
        end
      end
      S_HOLD: begin
        if (ip_hdr_ready)
          state_nx = (ip_payload_len == 16'd0) ? S_DROP : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        if (s_axis_tvalid) begin
          if (remaining == 16'd1) begin
            m_axis_tlast = 1'b1;
          end else if (s_axis_tlast) begin
            m_axis_tlast = 1'b1;
            m_axis_tuser = 1'b1;
          end
        end
        if (s_axis_tvalid && m_axis_tready) begin
          if (remaining == 16'd1)
            state_nx = s_axis_tlast ? S_IDLE : S_DROP;
          else if (s_axis_tlast)
            state_nx = S_IDLE;
        end
      end
      S_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      header_rd      <= 1'b0;
      ip_src_mac     <= '0;
      ip_src_addr    <= '0;
      ip_dst_addr    <= '0;
      ip_protocol    <= '0;
      ip_payload_len <= '0;
      drop_count     <= '0;
      byte_cnt       <= '0;
      vihl           <= '0;
      tot_len        <= '0;
      remaining      <= '0;
`ifdef IPV4_CSUM_CHECK_EN
      csum           <= '0;
      csum_hi        <= '0;
`endif
    end else begin
      header_rd <= (state == S_IDLE) && header_valid;
      if (drop_inc && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      if (state == S_IDLE) begin
        byte_cnt <= '0;
`ifdef IPV4_CSUM_CHECK_EN
        csum     <= '0;
`endif
        if (header_valid) ip_src_mac <= src_mac;
      end
      if ((state == S_HDR) && s_hs) begin
        byte_cnt <= byte_cnt + 5'd1;
        case (byte_cnt)
          5'd0:  vihl          <= s_axis_tdata;
          5'd2:  tot_len[15:8] <= s_axis_tdata;
          5'd3:  tot_len[7:0]  <= s_axis_tdata;
          5'd9:  ip_protocol   <= s_axis_tdata;
          5'd12, 5'd13, 5'd14, 5'd15:
                 ip_src_addr   <= {ip_src_addr[23:0], s_axis_tdata};
          5'd16, 5'd17, 5'd18, 5'd19:
                 ip_dst_addr   <= {ip_dst_addr[23:0], s_axis_tdata};
          default: ;
        endcase
        if (byte_cnt == 5'd19) ip_payload_len <= tot_len - 16'd20;
`ifdef IPV4_CSUM_CHECK_EN
        if (!byte_cnt[0]) csum_hi <= s_axis_tdata;
        else              csum    <= csum_next;
`endif
      end
      if ((state == S_HOLD) && (state_nx == S_PAYLOAD)) remaining <= ip_payload_len;
      if ((state == S_PAYLOAD) && s_hs) remaining <= remaining - 16'd1;
    end
  end

endmodule

// File: doc/ipv4_rx_parser.md
Name: ipv4_rx_parser

Overview:
- Sits directly downstream of packet_recv.
- Consumes the Ethernet header side-channel (header_valid/header_rd, dest_mac, src_mac, ethertype) and the byte-wide AXI-stream payload.
- Accepts only IPv4 frames with a 20-byte header. Parses the header into registered fields, forwards exactly total_length-20 payload bytes downstream, and discards Ethernet padding and rejected frames.

Parameters:
- IP_FILTER, 0, when 1 drop datagrams whose destination address differs from LOCAL_IP.
- LOCAL_IP, 32'hC0A8_0164, station IPv4 address used when IP_FILTER=1.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- header_valid  in  1  Ethernet header available from packet_recv.
- header_rd  out  1  one-cycle pulse consuming the Ethernet header.
- dest_mac  in  48  Ethernet destination MAC.
- src_mac  in  48  Ethernet source MAC.
- ethertype  in  16  Ethernet type/length field.
- s_axis_tdata  in  8  frame payload byte.
- s_axis_tvalid  in  1  upstream byte valid.
- s_axis_tlast  in  1  last byte of frame (excluding FCS).
- s_axis_tready  out  1  byte accepted.
- ip_hdr_valid  out  1  parsed IPv4 header fields valid.
- ip_hdr_ready  in  1  consumer accepts header fields.
- ip_src_mac  out  48  latched src_mac.
- ip_src_addr  out  32  IPv4 source address.
- ip_dst_addr  out  32  IPv4 destination address.
- ip_protocol  out  8  IPv4 protocol field.
- ip_payload_len  out  16  total_length-20.
- m_axis_tdata  out  8  IP payload byte.
- m_axis_tvalid  out  1  payload byte valid.
- m_axis_tlast  out  1  last IP payload byte.
- m_axis_tuser  out  1  with tlast: 1 means the datagram was truncated.
- m_axis_tready  in  1  downstream accepts byte.
- drop_count  out  16  saturating count of dropped frames.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0: header_rd, s_axis_tready, ip_hdr_valid, m_axis_tvalid/tlast/tuser, every field register, drop_count.
- IDLE:
  - s_axis_tready=0.
  - On header_valid=1: pulse header_rd for exactly one cycle and latch src_mac.
  - ethertype==16'h0800 -> HDR; any other value -> DROP with drop_count+1.
- HDR:
  - s_axis_tready=1; 5-bit byte counter runs 0..19.
  - Big-endian capture: byte0 version/IHL, bytes2-3 total_length, byte9 protocol, bytes12-15 src, bytes16-19 dst.
  - After byte19, DROP (drop_count+1) if any of these hold: version!=4, IHL!=5, total_length<20, or IP_FILTER=1 and dst!=LOCAL_IP. Otherwise -> HOLD.
  - s_axis_tlast seen before or on byte19 -> IDLE with drop_count+1.
- HOLD:
  - ip_hdr_valid=1 and s_axis_tready=0; fields stable.
  - On ip_hdr_valid&&ip_hdr_ready: clear ip_hdr_valid next cycle.
  - ip_payload_len==0 -> DROP without incrementing drop_count (discards the tail). Otherwise -> PAYLOAD.
- PAYLOAD:
  - Combinational pass-through: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
  - 16-bit remaining counter loads ip_payload_len and decrements on each handshake.
  - On the beat with remaining==1: m_axis_tlast=1, tuser=0. If s_axis_tlast is also 1 -> IDLE, else -> DROP (padding, no count).
  - s_axis_tlast with remaining>1: m_axis_tlast=1, tuser=1 on that beat -> IDLE.
- DROP:
  - s_axis_tready=1, m_axis_tvalid=0.
  - Consume bytes until a handshake with s_axis_tlast -> IDLE.
- drop_count saturates at 16'hFFFF.
- header_valid arriving outside IDLE is ignored until IDLE is re-entered.
- Zero-latency data path in PAYLOAD; no stream beat is ever emitted outside PAYLOAD.

Optional Feature:
- Macro: IPV4_CSUM_CHECK_EN.
- Defined:
  - HDR accumulates the 16-bit one's-complement sum of the ten header words with end-around carry.
  - After byte19, a folded sum !=16'hFFFF is treated as a header reject (-> DROP, drop_count+1). The check adds no cycles.
- Undefined: the checksum field is ignored and no adder logic is synthesized.

Test Plan:
- Frame with ethertype 16'h0806 and 46 bytes -> header_rd single pulse, all 46 bytes consumed, no m_axis beats, drop_count=1.
- IPv4 frame, total_length=16'h001C, src C0A8_0101, dst C0A8_0164, proto 8'h11, 18 pad bytes (46-byte payload) -> ip_hdr_valid with those fields, ip_payload_len=8, exactly 8 m_axis beats, tlast on 8th with tuser=0, pad bytes discarded, drop_count=0.
- Same frame, ip_hdr_ready held 0 for 10 cycles, then m_axis_tready toggling 1/0 -> fields stable for the whole hold, s_axis_tready=0 throughout HOLD, payload order preserved, no byte lost or duplicated.
- total_length=16'h0064 but s_axis_tlast after 30 payload bytes -> 30 beats, tlast+tuser=1 on the 30th, state IDLE.
- IHL=6 and a separate frame with version=6 -> both dropped, drop_count=2, no ip_hdr_valid.
- With IPV4_CSUM_CHECK_EN, correct checksum 16'hB861 (for the standard sample header) -> accepted; same header with the checksum flipped to 16'hB862 -> dropped, drop_count+1. rst_n asserted mid-PAYLOAD -> all outputs 0 immediately, state IDLE.
